// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types, presets and helpers for the parallel CRC engine
// Purpose: FSM state enum, bit-reverse helper and preset parameter constants
//          (ARC, CCITT-FALSE, MODBUS) used by crc_parallel_engine.
// Ports:   none (package).
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } crc_state_t;

   localparam logic [15:0] ARC_POLY           = 16'h8005;
   localparam logic [15:0] ARC_INIT           = 16'h0000;
   localparam logic [15:0] ARC_XOROUT         = 16'h0000;
   localparam bit          ARC_REFIN          = 1'b1;
   localparam bit          ARC_REFOUT         = 1'b1;

   localparam logic [15:0] CCITT_FALSE_POLY   = 16'h1021;
   localparam logic [15:0] CCITT_FALSE_INIT   = 16'hFFFF;
   localparam logic [15:0] CCITT_FALSE_XOROUT = 16'h0000;
   localparam bit          CCITT_FALSE_REFIN  = 1'b0;
   localparam bit          CCITT_FALSE_REFOUT = 1'b0;

   localparam logic [15:0] MODBUS_POLY        = 16'h8005;
   localparam logic [15:0] MODBUS_INIT        = 16'hFFFF;
   localparam logic [15:0] MODBUS_XOROUT      = 16'h0000;
   localparam bit          MODBUS_REFIN       = 1'b1;
   localparam bit          MODBUS_REFOUT      = 1'b1;

   // Reverses the low 'width' bits of value; bits above width come back as 0.
   function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                               input int unsigned width);
      logic [31:0] result;
      result = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) begin
            result[i] = value[5'(width - 32'd1 - i)];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - combinational single-byte CRC update
// Purpose: folds one byte into a CRC register, MSB-first shift convention.
// Ports:   crc_in    - register value before this byte
//          data_byte - byte to fold (reflected first when refin is set)
//          poly      - generator polynomial, normal form
//          refin     - reflect the byte before folding
//          crc_out   - register value after this byte
module crc_byte_step #(
   parameter int unsigned CRC_W = 16
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [7:0]       data_byte,
   input  logic [CRC_W-1:0] poly,
   input  logic             refin,
   output logic [CRC_W-1:0] crc_out
);

   logic [7:0]       byte_in;
   logic [CRC_W-1:0] acc;

   always_comb begin
      byte_in = data_byte;
      if (refin) begin
         for (int i = 0; i < 8; i++) begin
            byte_in[i] = data_byte[7-i];
         end
      end
      // Bit 7 of the (possibly reflected) byte enters the register first.
      acc = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (acc[CRC_W-1] ^ byte_in[i]) begin
            acc = (acc << 1) ^ poly;
         end else begin
            acc = acc << 1;
         end
      end
   end

   assign crc_out = acc;

endmodule

// File: rtl/crc_parallel_engine.sv
// rtl/crc_parallel_engine.sv - multi-byte-per-beat CRC engine with result handshake
// Purpose: folds DATA_W/8 bytes per accepted beat into a CRC register and
//          presents the finalised CRC with a valid/ready handshake.
// Ports:   clk, rst               - clock, synchronous active-high reset
//          data, data_keep        - beat payload (byte 0 first), byte enables
//          data_last, data_valid  - end-of-frame marker, beat present
//          data_ready             - high in IDLE/RUN, low while a result is held
//          crc_clear              - abort current frame (beats that cycle dropped)
//          crc, crc_valid         - finalised CRC and its valid flag
//          crc_ready              - result consumer ready
module crc_parallel_engine
   import crc_pkg::*;
#(
   parameter int unsigned      DATA_W = 8,
   parameter int unsigned      CRC_W  = 16,
   parameter logic [CRC_W-1:0] POLY   = CRC_W'(ARC_POLY),
   parameter logic [CRC_W-1:0] INIT   = CRC_W'(ARC_INIT),
   parameter logic [CRC_W-1:0] XOROUT = CRC_W'(ARC_XOROUT),
   parameter bit               REFIN  = ARC_REFIN,
   parameter bit               REFOUT = ARC_REFOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W/8-1:0] data_keep,
   input  logic                data_last,
   input  logic                data_valid,
   output logic                data_ready,
   input  logic                crc_clear,
   output logic [CRC_W-1:0]    crc,
   output logic                crc_valid,
   input  logic                crc_ready
);

   localparam int unsigned NB = DATA_W / 8;

   crc_state_t       state;
   logic [CRC_W-1:0] crc_reg;
   logic [NB-1:0]    keep_eff;
   logic [CRC_W-1:0] stage    [NB+1];
   logic [CRC_W-1:0] step_out [NB];
   logic             accept;

   // Only the last beat honours data_keep, and only up to its first 0 bit,
   // so the enabled bytes always form an LSB-contiguous prefix.
   always_comb begin
      keep_eff = '1;
      if (data_last) begin
         keep_eff[0] = data_keep[0];
         for (int i = 1; i < NB; i++) begin
            keep_eff[i] = keep_eff[i-1] & data_keep[i];
         end
      end
   end

   assign stage[0] = crc_reg;

   for (genvar g = 0; g < NB; g++) begin : g_step
      crc_byte_step #(
         .CRC_W(CRC_W)
      ) u_step (
         .crc_in   (stage[g]),
         .data_byte(data[8*g +: 8]),
         .poly     (POLY),
         .refin    (REFIN),
         .crc_out  (step_out[g])
      );
      assign stage[g+1] = keep_eff[g] ? step_out[g] : stage[g];
   end

   assign accept = data_valid && data_ready;

   always_ff @(posedge clk) begin
      if (rst || crc_clear) begin
         state      <= IDLE;
         crc_reg    <= INIT;
         crc_valid  <= 1'b0;
         data_ready <= 1'b1;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (accept) begin
                  crc_reg <= stage[NB];
                  if (data_last) begin
                     state      <= DONE;
                     crc_valid  <= 1'b1;
                     data_ready <= 1'b0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            DONE: begin
               if (crc_ready) begin
                  state      <= IDLE;
                  crc_reg    <= INIT;
                  crc_valid  <= 1'b0;
                  data_ready <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               crc_reg    <= INIT;
               crc_valid  <= 1'b0;
               data_ready <= 1'b1;
            end
         endcase
      end
   end

   // The register is frozen in DONE, so crc is stable while crc_valid is high.
   assign crc = (REFOUT ? CRC_W'(bit_reverse(32'(crc_reg), CRC_W)) : crc_reg) ^ XOROUT;

endmodule

// File: tb/tb_crc_parallel_engine.sv
// tb/tb_crc_parallel_engine.sv - bench for crc_parallel_engine (ARC/8, CCITT-FALSE/32, MODBUS/16)
module tb_crc_parallel_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic [3:0]  keep;
   logic        last;
   logic [2:0]  valid;
   logic [2:0]  ready;
   logic [2:0]  cvalid;
   logic        crc_clear;
   logic        crc_ready;
   logic [15:0] crc_o [3];

   int total = 0;
   int bad   = 0;
   logic [7:0] msg [$];

   always #5 clk = ~clk;

   crc_parallel_engine u_arc (
      .clk(clk), .rst(rst), .data(data[7:0]), .data_keep(keep[0:0]), .data_last(last),
      .data_valid(valid[0]), .data_ready(ready[0]), .crc_clear(crc_clear),
      .crc(crc_o[0]), .crc_valid(cvalid[0]), .crc_ready(crc_ready));

   crc_parallel_engine #(
      .DATA_W(32), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
      .REFIN(1'b0), .REFOUT(1'b0)
   ) u_ccitt (
      .clk(clk), .rst(rst), .data(data), .data_keep(keep), .data_last(last),
      .data_valid(valid[1]), .data_ready(ready[1]), .crc_clear(crc_clear),
      .crc(crc_o[1]), .crc_valid(cvalid[1]), .crc_ready(crc_ready));

   crc_parallel_engine #(
      .DATA_W(16), .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .XOROUT(16'h0000),
      .REFIN(1'b1), .REFOUT(1'b1)
   ) u_modbus (
      .clk(clk), .rst(rst), .data(data[15:0]), .data_keep(keep[1:0]), .data_last(last),
      .data_valid(valid[2]), .data_ready(ready[2]), .crc_clear(crc_clear),
      .crc(crc_o[2]), .crc_valid(cvalid[2]), .crc_ready(crc_ready));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int beat_bytes(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 4 : 2;
   endfunction

   // Textbook bit-serial CRC over the message bit stream.
   function automatic logic [15:0] model(input int sel);
      logic [15:0] poly, r, xo, res;
      logic [7:0]  c;
      bit ri, ro, fb;
      case (sel)
         0:       begin poly = 16'h8005; r = 16'h0000; xo = 16'h0000; ri = 1; ro = 1; end
         1:       begin poly = 16'h1021; r = 16'hFFFF; xo = 16'h0000; ri = 0; ro = 0; end
         default: begin poly = 16'h8005; r = 16'hFFFF; xo = 16'h0000; ri = 1; ro = 1; end
      endcase
      foreach (msg[i]) begin
         c = msg[i];
         for (int j = 0; j < 8; j++) begin
            fb = r[15] ^ (ri ? c[j] : c[7-j]);
            r  = r << 1;
            if (fb) r = r ^ poly;
         end
      end
      res = r;
      if (ro) for (int k = 0; k < 16; k++) res[k] = r[15-k];
      return res ^ xo;
   endfunction

   task automatic set_str(input string s);
      msg = {};
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
   endtask

   // Drives msg as beats to DUT 'sel'. Padding bytes are random; keep bits above
   // the first 0 on the last beat are random to exercise truncation.
   task automatic send_frame(input int sel, input bit with_last);
      int bw = beat_bytes(sel);
      int n  = msg.size();
      int nb = (n == 0) ? 1 : (n + bw - 1) / bw;
      int cnt;
      int rem;
      for (int b = 0; b < nb; b++) begin
         @(negedge clk);
         rem  = n - b * bw;
         last = with_last && (b == nb - 1);
         keep = 4'($urandom);
         for (int k = 0; k < 4; k++) begin
            data[8*k +: 8] = (k < bw && b * bw + k < n) ? msg[b * bw + k] : 8'($urandom);
            if (last) keep[k] = (k < rem) ? 1'b1 : (k == rem) ? 1'b0 : 1'($urandom);
         end
         valid      = '0;
         valid[sel] = 1'b1;
         cnt = 0;
         while (!ready[sel] && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
         chk($sformatf("ready_wait%0d", sel), ready[sel], 1);
         @(posedge clk);
      end
      @(negedge clk);
      valid = '0;
      last  = 1'b0;
      if (with_last) chk($sformatf("latency%0d", sel), cvalid[sel], 1);
   endtask

   task automatic check_result(input int sel, input logic [15:0] exp, input string tag);
      chk(tag, crc_o[sel], exp);
      if (crc_ready) begin
         @(negedge clk);
         chk({tag, "_vdrop"}, cvalid[sel], 0);
         chk({tag, "_rdy"}, ready[sel], 1);
      end
   endtask

   initial begin
      rst = 1'b1; data = '0; keep = '0; last = 1'b0; valid = '0;
      crc_clear = 1'b0; crc_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_valid_arc", cvalid[0], 0);
      chk("rst_ready_arc", ready[0], 1);
      chk("rst_crc_arc", crc_o[0], 16'h0000);
      chk("rst_crc_ccitt", crc_o[1], 16'hFFFF);
      chk("rst_crc_modbus", crc_o[2], 16'hFFFF);
      chk("rst_ready_all", ready, 3'b111);

      // Directed check values
      set_str("123456789"); send_frame(0, 1); check_result(0, 16'hBB3D, "arc_check");
      set_str("123456789"); send_frame(1, 1); check_result(1, 16'h29B1, "ccitt_check");
      set_str("123456789"); send_frame(2, 1); check_result(2, 16'h4B37, "modbus_check");

      // Backpressure: held result, offered beats ignored
      crc_ready = 1'b0;
      set_str("123456789"); send_frame(0, 1);
      for (int i = 0; i < 5; i++) begin
         data = 32'h41; keep = 4'h1; last = 1'b1; valid = 3'b001;
         @(negedge clk);
         chk("bp_ready", ready[0], 0);
         chk("bp_valid", cvalid[0], 1);
         chk("bp_crc", crc_o[0], 16'hBB3D);
      end
      valid = '0; last = 1'b0; crc_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", cvalid[0], 0);
      set_str("xyz"); send_frame(0, 1); check_result(0, model(0), "bp_next");

      // Abort after 4 beats; beat offered with crc_clear must be dropped
      set_str("1234"); send_frame(0, 0);
      crc_clear = 1'b1; data = 32'h35; keep = 4'h1; last = 1'b1; valid = 3'b001;
      @(posedge clk);
      @(negedge clk);
      crc_clear = 1'b0; valid = '0; last = 1'b0;
      chk("abort_valid", cvalid[0], 0);
      chk("abort_ready", ready[0], 1);
      set_str("123456789"); send_frame(0, 1); check_result(0, 16'hBB3D, "abort_after");

      // Reset while in DONE
      crc_ready = 1'b0;
      set_str("123456789"); send_frame(0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstdone_valid", cvalid[0], 0);
      chk("rstdone_ready", ready[0], 1);
      chk("rstdone_crc", crc_o[0], 16'h0000);
      crc_ready = 1'b1;
      set_str("123456789"); send_frame(0, 1); check_result(0, 16'hBB3D, "rstdone_after");

      // Random frames on every configuration, including empty last beats
      for (int sel = 0; sel < 3; sel++) begin
         for (int f = 0; f < 8; f++) begin
            int len = (f == 0) ? 0 : int'($urandom_range(1, 13));
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_frame(sel, 1);
            check_result(sel, model(sel), $sformatf("rand%0d_%0d", sel, f));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crc_parallel_engine.md
CRC_PARALLEL_ENGINE -- requirements
Module: crc_parallel_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The parameters SHALL be:
- DATA_W, default 8, input beat width in bits (8, 16 or 32).
- CRC_W, default 16, CRC width in bits (8..32).
- POLY, default 16'h8005, generator polynomial in normal form.
- INIT, default 16'h0000, register preset at start of frame.
- XOROUT, default 16'h0000, final XOR mask.
- REFIN, default 1, reflect each input byte.
- REFOUT, default 1, reflect the final CRC.
REQ-003 The ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- data  in  DATA_W  beat payload; byte 0 is data[7:0] and is processed first.
- data_keep  in  DATA_W/8  byte enables; examined only on the last beat.
- data_last  in  1  marks the final beat of a frame.
- data_valid  in  1  beat present.
- data_ready  out  1  beat accepted when data_valid and data_ready are both high.
- crc_clear  in  1  aborts the current frame.
- crc  out  CRC_W  final CRC after REFOUT and XOROUT.
- crc_valid  out  1  result present.
- crc_ready  in  1  result consumed when crc_valid and crc_ready are both high.

Function
REQ-004 The FSM SHALL have three states:
- IDLE: register equals INIT.
- RUN: frame in progress.
- DONE: result held.
REQ-005 An accepted beat SHALL fold all enabled bytes into the running register in a single cycle, byte 0 first.
REQ-006 Non-last beats SHALL treat every data_keep bit as 1.
REQ-007 On the last beat, data_keep SHALL be LSB-contiguous. A non-contiguous pattern SHALL be truncated at its first 0.
REQ-008 A last beat with data_keep all zero SHALL finalise without folding any bytes.
REQ-009 Transitions SHALL be:
- IDLE to RUN on an accepted non-last beat.
- IDLE or RUN to DONE on an accepted last beat.
- DONE to IDLE on a crc handshake, with the register reloaded to INIT.
REQ-010 data_ready SHALL be 1 in IDLE and RUN and 0 in DONE, which provides backpressure until the result is consumed.
REQ-011 crc_valid SHALL be asserted in the cycle after the last-beat handshake, giving a latency of 1 cycle.
REQ-012 While crc_valid is high, crc SHALL stay stable until crc_ready is sampled high.
REQ-013 A single-beat frame SHALL go from IDLE to DONE directly.
REQ-014 Back-to-back frames SHALL be supported: after the crc handshake, the next beat is accepted the following cycle, giving a throughput of 1 frame per (beats + 1) cycles.
REQ-015 crc_clear SHALL have priority over any handshake in the same cycle. It forces IDLE, reloads INIT and deasserts crc_valid in the next cycle, and the beat offered in that cycle is not accepted.
REQ-016 The final CRC SHALL be computed as (REFOUT ? reverse(reg) : reg) XOR XOROUT. All arithmetic SHALL be modulo-2 at CRC_W bits, with the MSB-first shift convention.
REQ-017 Input to the block SHALL be ignored while data_ready is 0.

Reset
REQ-018 While rst is high at a clk edge, the next state SHALL be:
- FSM in IDLE and register equal to INIT.
- crc_valid 0.
- crc equal to the value of (INIT reflected per REFOUT) XOR XOROUT.
- data_ready 1 from the first cycle after reset.
REQ-019 A reset mid-frame or in DONE SHALL discard all partial and pending results without producing a crc_valid pulse.

Structure
REQ-020 A shared package crc_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the bit-reverse function;
- default parameter constants for the ARC, CCITT-FALSE and MODBUS presets.
REQ-021 The single-byte update SHALL be a combinational sub-module crc_byte_step (inputs: reg, byte, POLY, REFIN). It SHALL be instantiated DATA_W/8 times in a cascade, with each stage's output selected by the corresponding effective keep bit.
REQ-022 The block SHALL contain no other sub-modules.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Defaults (ARC), DATA_W=8: "123456789" as 9 beats with last on the 9th, crc_ready=1 -> crc=16'hBB3D with crc_valid high exactly one cycle after the 9th beat.
- CCITT-FALSE (POLY=16'h1021, INIT=16'hFFFF, REFIN=0, REFOUT=0), DATA_W=32: "123456789" as 3 beats, the last with data_keep=4'b0001 -> crc=16'h29B1.
- MODBUS (POLY=16'h8005, INIT=16'hFFFF, REFIN=1, REFOUT=1), DATA_W=16: same string as 5 beats, the last with data_keep=2'b01 -> crc=16'h4B37.
- Backpressure: hold crc_ready=0 for 5 cycles after crc_valid -> data_ready stays 0, crc is stable and the next frame is not started; release -> the next frame's result is also correct.
- Abort: assert crc_clear after beat 4 of "123456789", then send the full string -> crc=16'hBB3D (defaults), with no crc_valid for the aborted frame.
- Reset: assert rst while in DONE -> crc_valid=0 and data_ready=1 in the next cycle; a subsequent frame yields the correct CRC.
